// File: rtl/i2c_cmd_master.sv
// Single-byte I2C master: one i2c_exec strobe becomes START, device address, register byte(s),
// data write or RESTART+read, then STOP and a one-cycle i2c_done pulse.
module i2c_cmd_master #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned I2C_FREQ   = 400_000,
  parameter logic [6:0]  SLAVE_ADDR = 7'h3C,
  parameter bit          BIT_CTRL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i2c_exec,
  input  logic        i2c_rh_wl,
  input  logic [15:0] i2c_addr,
  input  logic [7:0]  i2c_data_w,
  output logic [7:0]  i2c_data_r,
  output logic        i2c_done,
  output logic        i2c_ack,
  output logic        busy,
  output logic        scl,
  output logic        sda_o,
  output logic        sda_oe,
  input  logic        sda_i
);

  localparam int unsigned QDIV = CLK_FREQ / (I2C_FREQ * 4);
  localparam int unsigned CntW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(QDIV - 1);

  typedef enum logic [3:0] {
    StIdle, StStart, StDevW, StAddrH, StAddrL, StWrData,
    StRestart, StDevR, StRdData, StStop, StDone
  } state_e;

  state_e          st_q, st_d;
  logic [1:0]      q_q, q_d;
  logic [3:0]      bit_q, bit_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rw_q, rw_d;
  logic [15:0]     addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            ack_q, ack_d;
  logic [7:0]      rd_sh_q, rd_sh_d;
  logic [7:0]      data_r_q, data_r_d;

  logic            tick;
  logic            tx_state;
  logic [7:0]      tx_byte;
  state_e          byte_next;

  assign tick = (cnt_q == CntMax);

  // Byte the master shifts out in the current state, and where the FSM goes after its ACK slot.
  always_comb begin
    tx_state  = 1'b1;
    tx_byte   = 8'hFF;
    byte_next = StStop;
    unique case (st_q)
      StDevW: begin
        tx_byte   = {SLAVE_ADDR, 1'b0};
        byte_next = BIT_CTRL ? StAddrH : StAddrL;
      end
      StAddrH: begin
        tx_byte   = addr_q[15:8];
        byte_next = StAddrL;
      end
      StAddrL: begin
        tx_byte   = addr_q[7:0];
        byte_next = rw_q ? StRestart : StWrData;
      end
      StWrData: begin
        tx_byte   = wdata_q;
        byte_next = StStop;
      end
      StDevR: begin
        tx_byte   = {SLAVE_ADDR, 1'b1};
        byte_next = StRdData;
      end
      default: tx_state = 1'b0;
    endcase
  end

  always_comb begin
    st_d     = st_q;
    q_d      = q_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack_d    = ack_q;
    rd_sh_d  = rd_sh_q;
    data_r_d = data_r_q;
    if (st_q == StIdle) begin
      cnt_d = '0;
      if (i2c_exec) begin
        st_d    = StStart;
        q_d     = 2'd0;
        bit_d   = 4'd0;
        rw_d    = i2c_rh_wl;
        addr_d  = i2c_addr;
        wdata_d = i2c_data_w;
        ack_d   = 1'b0;
      end
    end else if (st_q == StDone) begin
      st_d  = StIdle;
      cnt_d = '0;
    end else begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        q_d = q_q + 2'd1;
        if (q_q == 2'd2 && bit_q == 4'd8 && tx_state) ack_d = ack_q | sda_i;
        if (q_q == 2'd2 && st_q == StRdData && bit_q < 4'd8) rd_sh_d = {rd_sh_q[6:0], sda_i};
        if (q_q == 2'd3) begin
          bit_d = bit_q + 4'd1;
          unique case (st_q)
            StStart: begin
              st_d  = StDevW;
              bit_d = 4'd0;
            end
            StRestart: begin
              st_d  = StDevR;
              bit_d = 4'd0;
            end
            StStop: begin
              st_d = StDone;
              if (rw_q) data_r_d = rd_sh_q;
            end
            default: begin
              if (bit_q == 4'd8) begin
                bit_d = 4'd0;
                st_d  = byte_next;
              end
            end
          endcase
        end
      end
    end
  end

  // Bus drive decoded from state and quarter; SDA is only ever pulled low or released.
  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    unique case (st_q)
      StStart: begin
        scl    = (q_q != 2'd3);
        sda_oe = (q_q >= 2'd2);
      end
      StRestart: begin
        scl    = (q_q == 2'd1) || (q_q == 2'd2);
        sda_oe = (q_q >= 2'd2);
      end
      StStop: begin
        scl    = (q_q != 2'd0);
        sda_oe = (q_q <= 2'd1);
      end
      StDevW, StAddrH, StAddrL, StWrData, StDevR, StRdData: begin
        scl    = (q_q == 2'd1) || (q_q == 2'd2);
        sda_oe = tx_state && (bit_q < 4'd8) && !tx_byte[3'd7 - bit_q[2:0]];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= StIdle;
      q_q      <= 2'd0;
      bit_q    <= 4'd0;
      cnt_q    <= '0;
      rw_q     <= 1'b0;
      addr_q   <= 16'h0000;
      wdata_q  <= 8'h00;
      ack_q    <= 1'b0;
      rd_sh_q  <= 8'h00;
      data_r_q <= 8'h00;
    end else begin
      st_q     <= st_d;
      q_q      <= q_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack_q    <= ack_d;
      rd_sh_q  <= rd_sh_d;
      data_r_q <= data_r_d;
    end
  end

  assign busy       = (st_q != StIdle);
  assign i2c_done   = (st_q == StDone);
  assign i2c_ack    = ack_q;
  assign i2c_data_r = data_r_q;
  assign sda_o      = 1'b0;

endmodule

// File: tb/tb_i2c_cmd_master.sv
// Bench for i2c_cmd_master: an I2C slave model logs bus events, and a timing model derived from
// transaction length checks busy/done/scl every cycle.
module tb_i2c_cmd_master;

  localparam int Q    = 50_000_000 / (400_000 * 4);
  localparam int EvS  = 256;
  localparam int EvP  = 257;
  localparam int EvSr = 258;
  localparam int EvMN = 259;
  localparam int EvMA = 260;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exec = 1'b0;
  logic        rh_wl = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  data_w = 8'h00;
  logic        sel = 1'b0;
  logic        sl_low = 1'b0;

  logic [7:0] data_r0, data_r1;
  logic done0, done1, ack0, ack1, busy0, busy1, scl0, scl1, sdao0, sdao1, oe0, oe1;
  logic sda0, sda1, exec0, exec1;
  logic m_scl, m_sda, m_busy, m_done, m_ack, m_sdao, m_oe;
  logic [7:0] m_data_r;

  assign exec0 = exec & ~sel;
  assign exec1 = exec & sel;
  assign sda0  = ~oe0 & ~(sl_low & ~sel);
  assign sda1  = ~oe1 & ~(sl_low & sel);
  assign m_scl    = sel ? scl1 : scl0;
  assign m_sda    = sel ? sda1 : sda0;
  assign m_busy   = sel ? busy1 : busy0;
  assign m_done   = sel ? done1 : done0;
  assign m_ack    = sel ? ack1 : ack0;
  assign m_sdao   = sel ? sdao1 : sdao0;
  assign m_oe     = sel ? oe1 : oe0;
  assign m_data_r = sel ? data_r1 : data_r0;

  i2c_cmd_master #(.BIT_CTRL(1'b0)) u_dut (
    .clk(clk), .rst(rst), .i2c_exec(exec0), .i2c_rh_wl(rh_wl), .i2c_addr(addr),
    .i2c_data_w(data_w), .i2c_data_r(data_r0), .i2c_done(done0), .i2c_ack(ack0), .busy(busy0),
    .scl(scl0), .sda_o(sdao0), .sda_oe(oe0), .sda_i(sda0)
  );

  i2c_cmd_master #(.BIT_CTRL(1'b1)) u_dut16 (
    .clk(clk), .rst(rst), .i2c_exec(exec1), .i2c_rh_wl(rh_wl), .i2c_addr(addr),
    .i2c_data_w(data_w), .i2c_data_r(data_r1), .i2c_done(done1), .i2c_ack(ack1), .busy(busy1),
    .scl(scl1), .sda_o(sdao1), .sda_oe(oe1), .sda_i(sda1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave model: logs START/RESTART/STOP and bytes, ACKs writes, serves rd_byte on reads.
  int   log_q[$];
  int   exp_log[$];
  bit   nack_dev = 1'b0;
  logic [7:0] rd_byte = 8'hA5;

  initial begin
    logic pscl, psda, c_scl, c_sda, stx, mnack, in_txn;
    logic [7:0] shreg;
    int bitn, bidx;
    pscl = 1; psda = 1; stx = 0; mnack = 0; in_txn = 0; shreg = 0; bitn = 0; bidx = 0;
    forever begin
      @(negedge clk);
      c_scl = m_scl;
      c_sda = m_sda;
      if (rst) begin
        sl_low = 0; stx = 0; in_txn = 0; bitn = 0; bidx = 0;
      end else if (pscl && c_scl && psda && !c_sda) begin
        log_q.push_back(in_txn ? EvSr : EvS);
        in_txn = 1; bitn = 0; bidx = 0; stx = 0; sl_low = 0;
      end else if (pscl && c_scl && !psda && c_sda) begin
        log_q.push_back(EvP);
        in_txn = 0; bitn = 0; stx = 0; sl_low = 0;
      end else if (!pscl && c_scl) begin
        if (!stx && bitn < 8) shreg = {shreg[6:0], c_sda};
        if (stx && bitn == 8) begin
          mnack = c_sda;
          log_q.push_back(c_sda ? EvMN : EvMA);
        end
        bitn++;
      end else if (pscl && !c_scl) begin
        if (bitn == 8) begin
          if (stx) sl_low = 0;
          else begin
            log_q.push_back(int'(shreg));
            sl_low = !(nack_dev && bidx == 0);
          end
        end else if (bitn == 9) begin
          if (!stx && bidx == 0 && shreg[0]) stx = 1;
          else if (stx && mnack) stx = 0;
          sl_low = stx && !rd_byte[7];
          bidx++;
          bitn = 0;
        end else if (stx && bitn >= 1 && bitn <= 7) begin
          sl_low = !rd_byte[7 - bitn];
        end
      end
      pscl = c_scl;
      psda = c_sda;
    end
  end

  // Timing model: a transaction of lat quarters is START, bits, [RESTART,] bits, STOP,
  // each 4 quarters of Q clocks; done comes in the cycle right after the last quarter.
  bit mon_on = 1'b0;
  int acc_cyc = 0;
  int exp_lat = 0;
  int done_cnt = 0;
  int done_k = -1;

  function automatic logic model_scl(input int k, input int lat);
    int qi, e, qq;
    qi = k / Q;
    e  = qi / 4;
    qq = qi % 4;
    if (e == 0) return qq != 3;
    if (e == lat / 4 - 1) return qq != 0;
    return (qq == 1) || (qq == 2);
  endfunction

  initial begin
    int k, lim;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        k   = cyc - acc_cyc;
        lim = exp_lat * Q;
        chk("busy", m_busy, k <= lim);
        chk("done", m_done, k == lim);
        chk("scl", m_scl, (k < lim) ? model_scl(k, exp_lat) : 1'b1);
        chk("sda_o", m_sdao, 1'b0);
        if (m_done) begin
          done_cnt++;
          done_k = k;
        end
      end
    end
  end

  task automatic run_txn(input logic s, input logic rd, input logic [15:0] a,
                         input logic [7:0] d, input int lat, input int lit_done,
                         input bit inject);
    sel = s;
    log_q.delete();
    done_cnt = 0;
    done_k   = -1;
    exp_lat  = lat;
    @(posedge clk);
    #2;
    exec = 1; rh_wl = rd; addr = a; data_w = d;
    @(posedge clk);
    #2;
    exec = 0;
    acc_cyc = cyc;
    mon_on = 1;
    for (int k = 1; k <= lat * Q + 4; k++) begin
      @(posedge clk);
      #2;
      exec = inject && (k == 1000 || k == lat * Q);
      if (exec) begin
        data_w = 8'hFF;
        rh_wl  = 1'b1;
      end
    end
    exec = 0;
    mon_on = 0;
    chk("done_pulses", done_cnt, 1);
    chk("done_cycle", done_k, lit_done);
  endtask

  task automatic chk_log(input string name);
    int n;
    chk({name, "_len"}, log_q.size(), exp_log.size());
    n = (log_q.size() < exp_log.size()) ? log_q.size() : exp_log.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_ev%0d", name, i), log_q[i], exp_log[i]);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", scl0, 1'b1);
    chk("rst_oe", oe0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_ack", ack0, 1'b0);
    chk("rst_data_r", data_r0, 8'h00);
    chk("rst16_scl", scl1, 1'b1);
    chk("rst16_busy", busy1, 1'b0);
    @(posedge clk);
    #2;
    rst = 0;
    repeat (3) @(posedge clk);

    // Command write, all ACKed.
    run_txn(1'b0, 1'b0, 16'h0000, 8'hAE, 116, 3596, 1'b0);
    chk("wr_ack", ack0, 1'b0);
    exp_log = '{EvS, 'h78, 'h00, 'hAE, EvP};
    chk_log("wr_log");

    // Read returns rd_byte; master NACKs it.
    run_txn(1'b0, 1'b1, 16'h0012, 8'h00, 156, 4836, 1'b0);
    chk("rd_data", data_r0, 8'hA5);
    chk("rd_ack", ack0, 1'b0);
    exp_log = '{EvS, 'h78, 'h12, EvSr, 'h79, EvMN, EvP};
    chk_log("rd_log");

    // Data write with device byte NACKed: still runs to STOP, ack flag set, data_r held.
    nack_dev = 1'b1;
    run_txn(1'b0, 1'b0, 16'h0040, 8'h24, 116, 3596, 1'b0);
    nack_dev = 1'b0;
    chk("nack_ack", ack0, 1'b1);
    chk("nack_data_r_held", data_r0, 8'hA5);
    exp_log = '{EvS, 'h78, 'h40, 'h24, EvP};
    chk_log("nack_log");

    // Asynchronous reset in the middle of a byte.
    sel = 0;
    log_q.delete();
    @(posedge clk);
    #2;
    exec = 1; rh_wl = 0; addr = 16'h0000; data_w = 8'h3C;
    @(posedge clk);
    #2;
    exec = 0;
    repeat (500) @(posedge clk);
    #3;
    rst = 1;
    #1;
    chk("arst_scl", scl0, 1'b1);
    chk("arst_oe", oe0, 1'b0);
    chk("arst_busy", busy0, 1'b0);
    chk("arst_done", done0, 1'b0);
    chk("arst_ack", ack0, 1'b0);
    chk("arst_data_r", data_r0, 8'h00);
    @(posedge clk);
    #2;
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_busy", busy0, 1'b0);
      chk("post_rst_done", done0, 1'b0);
    end

    // 16-bit register address.
    run_txn(1'b1, 1'b0, 16'h1234, 8'h55, 152, 4712, 1'b0);
    chk("w16_ack", ack1, 1'b0);
    exp_log = '{EvS, 'h78, 'h12, 'h34, 'h55, EvP};
    chk_log("w16_log");

    // Strobes mid-transfer and in the done cycle must be ignored.
    run_txn(1'b0, 1'b0, 16'h0000, 8'h11, 116, 3596, 1'b1);
    exp_log = '{EvS, 'h78, 'h00, 'h11, EvP};
    chk_log("busy_log");
    repeat (50) @(negedge clk);
    chk("busy_idle_after", busy0, 1'b0);
    chk("busy_oe_after", m_oe, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
